vector_unpacker: RTL and testbench
==================================

# vector_unpacker

Streaming splitter that accepts IN_W-bit words over a valid/ready handshake and emits them as IN_W/OUT_W consecutive OUT_W-bit slices, one per accepted output beat. It is the receive-side counterpart of our field-concatenation logic: words built as {hi_field, lo_field} are taken back apart into their fields. It sits between a byte-wide source and nibble/field-wide consumers in the vector datapath.

## Interface
- IN_W, 8, input word width; must be an integer multiple of OUT_W.
- OUT_W, 4, output slice width.
- MSB_FIRST, 1, 1 = emit slice [IN_W-1 -: OUT_W] first; 0 = emit [OUT_W-1:0] first.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  IN_W  word to unpack.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  OUT_W  current slice.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts slice.
- out_last  out  1  current slice is the final slice of its word.
- word_cnt  out  16  completed-word counter (only with VECTOR_UNPACKER_STATS_EN).

## Operation
- R = IN_W/OUT_W; slice index counter idx is clog2(R) bits (min 1).
- States: EMPTY (no word held), HOLD (word in holding register, slices pending).
- EMPTY: in_ready=1; on in_valid, latch in_data, idx<=0, go HOLD.
- HOLD: out_valid=1; out_data = slice idx counted from the MSB end if MSB_FIRST=1, else from the LSB end; out_last=(idx==R-1).
- HOLD, out_valid&out_ready, idx<R-1: idx<=idx+1.
- HOLD, out_valid&out_ready&out_last: word done. in_ready=1 combinationally in this cycle only; if in_valid, latch new word, idx<=0, stay HOLD (no bubble); else go EMPTY.
- in_ready=0 in HOLD except the final-slice-accepted cycle; in_data ignored when in_ready=0.
- out_valid deasserts only after acceptance; out_data/out_last stable while out_valid&!out_ready.
- Slices are pure bit-selects; no arithmetic, no sign handling.

## Timing
- Reset (rst_n=0, any time, async): state EMPTY, idx=0, holding register=0, out_valid=0, out_data=0, out_last=0, in_ready=1 once reset deasserts (0 during reset), word_cnt=0.
- Reset mid-word discards remaining slices; no partial output after release.
- Latency: word accepted at edge N -> first slice valid in cycle N+1.
- Throughput: one slice per cycle under continuous out_ready; one word per R cycles with no idle cycle between words.
- in_ready depends combinationally on out_ready in the final-slice cycle; out_valid/out_data/out_last are registered-state outputs with no combinational path from in_*.
- R=1 (IN_W==OUT_W): every slice has out_last=1; block acts as a one-entry pipeline register.

## Configuration
- VECTOR_UNPACKER_STATS_EN defined: word_cnt port present; increments by 1 on each final-slice acceptance, wraps 16'hFFFF -> 16'h0000, cleared by reset.
- Undefined: word_cnt port and counter absent; all other behaviour identical.

## Test plan
- Defaults, in 8'hF5 with out_ready=1 -> out 4'hF (last=0) then 4'h5 (last=1) on consecutive cycles; back to EMPTY, in_ready=1.
- Back-to-back 8'hA3, 8'h0E, in_valid held, out_ready=1 -> A,3,0,E on four consecutive cycles, no bubble; in_ready high only in EMPTY and the 4'h3 acceptance cycle.
- 8'h5C with out_ready=0 for 3 cycles then 1 -> out_data holds 4'h5, out_valid=1, in_ready=0 throughout stall; then 4'h5, 4'hC.
- MSB_FIRST=0, in 8'hF5 -> 4'h5 then 4'hF; IN_W=12,OUT_W=4,MSB_FIRST=1, 12'hABC -> A,B,C with last on C.
- rst_n low asynchronously after 4'hA of 8'hA3 is accepted -> out_valid=0 immediately; after release no 4'h3 appears, in_ready=1.
- With VECTOR_UNPACKER_STATS_EN, force 65536 words -> word_cnt wraps to 0; reset clears it.

Source files
------------

// File: rtl/vector_unpacker.sv
// Splits IN_W-bit words into IN_W/OUT_W slices of OUT_W bits, one per accepted output beat.
// Optional completed-word counter on port word_cnt when VECTOR_UNPACKER_STATS_EN is defined.
module vector_unpacker #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef VECTOR_UNPACKER_STATS_EN
    ,
    output logic [15:0]      word_cnt
`endif
);

    localparam int R     = IN_W / OUT_W;
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic              out_fire_s;
    logic              final_s;
    logic              accept_s;
    logic [IN_W-1:0]   shifted_s;

    assign out_valid  = (state_q == ST_HOLD);
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign out_fire_s = out_valid && out_ready;
    assign final_s    = out_fire_s && out_last;
    // A new word may enter in the same cycle the last slice of the previous one leaves.
    assign in_ready   = rst_n && ((state_q == ST_EMPTY) || final_s);
    assign accept_s   = in_valid && in_ready;

    // Slice selection: pure bit-select of the holding register by slice index.
    always_comb begin
        shifted_s = hold_q;
        if (MSB_FIRST != 0) begin
            shifted_s = hold_q << (int'(idx_q) * OUT_W);
            out_data  = shifted_s[IN_W-1 -: OUT_W];
        end else begin
            shifted_s = hold_q >> (int'(idx_q) * OUT_W);
            out_data  = shifted_s[OUT_W-1:0];
        end
    end

    // Next-state logic for state, slice index and holding register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    hold_d  = in_data;
                    idx_d   = IDX_ZERO;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (final_s) begin
                    idx_d = IDX_ZERO;
                    if (accept_s) begin
                        hold_d  = in_data;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (out_fire_s) begin
                    idx_d = idx_q + IDX_ONE;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= IDX_ZERO;
            hold_q  <= {IN_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

`ifdef VECTOR_UNPACKER_STATS_EN
    logic [15:0] cnt_q;

    // Completed-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (final_s) begin
            cnt_q <= cnt_q + 16'h0001;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_vector_unpacker.sv
// Bench for vector_unpacker: three instances (8/4 MSB-first, 8/4 LSB-first, 12/4 MSB-first)
// driven by shared handshake inputs, checked against a queue-based slice model and a vector table.
module tb_vector_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data8 = 8'h00;
    logic [11:0] in_data12 = 12'h000;

    logic       a_in_ready, a_valid, a_last;
    logic [3:0] a_data;
    logic       b_in_ready, b_valid, b_last;
    logic [3:0] b_data;
    logic       c_in_ready, c_valid, c_last;
    logic [3:0] c_data;
`ifdef VECTOR_UNPACKER_STATS_EN
    logic [15:0] a_cnt, b_cnt, c_cnt;
    logic [15:0] cnt_model = 16'h0000;
`endif

    int checks = 0;
    int failures = 0;
    int qa[$];
    int qb[$];
    int qc[$];

    typedef struct {
        logic [7:0] din;
        logic       vin;
        logic       rdy;
        logic [3:0] edata;
        logic       evalid;
        logic       elast;
        logic       eir;
    } vec_t;

    vec_t vecs[15];
    int   row_active = 0;
    int   row_idx = 0;

    always #5 clk = ~clk;

    vector_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .out_last(a_last)
`ifdef VECTOR_UNPACKER_STATS_EN
        , .word_cnt(a_cnt)
`endif
    );

    vector_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .out_last(b_last)
`ifdef VECTOR_UNPACKER_STATS_EN
        , .word_cnt(b_cnt)
`endif
    );

    vector_unpacker #(.IN_W(12), .OUT_W(4), .MSB_FIRST(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data12), .in_valid(in_valid),
        .in_ready(c_in_ready), .out_data(c_data), .out_valid(c_valid),
        .out_ready(out_ready), .out_last(c_last)
`ifdef VECTOR_UNPACKER_STATS_EN
        , .word_cnt(c_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Pending slices of one instance are a queue: head is the current slice, size 1 means last.
    task automatic chk_dut(input string tag, input int sz, input int head, input logic v,
                           input logic [3:0] d, input logic l, input logic ir, output logic eir);
        eir = rst_n && ((sz == 0) || ((sz == 1) && out_ready));
        chk({tag, ".out_valid"}, {31'd0, v}, {31'd0, sz > 0});
        chk({tag, ".out_last"}, {31'd0, l}, {31'd0, sz == 1});
        chk({tag, ".in_ready"}, {31'd0, ir}, {31'd0, eir});
        if (sz > 0) chk({tag, ".out_data"}, {28'd0, d}, head);
    endtask

    task automatic step();
        logic ir_a, ir_b, ir_c;
        int sa, sb, sc;
        @(negedge clk);
        sa = qa.size();
        sb = qb.size();
        sc = qc.size();
        chk_dut("a", sa, (sa > 0) ? qa[0] : 0, a_valid, a_data, a_last, a_in_ready, ir_a);
        chk_dut("b", sb, (sb > 0) ? qb[0] : 0, b_valid, b_data, b_last, b_in_ready, ir_b);
        chk_dut("c", sc, (sc > 0) ? qc[0] : 0, c_valid, c_data, c_last, c_in_ready, ir_c);
        if (row_active != 0) begin
            chk($sformatf("tbl%0d.out_valid", row_idx), {31'd0, a_valid}, {31'd0, vecs[row_idx].evalid});
            chk($sformatf("tbl%0d.out_last", row_idx), {31'd0, a_last}, {31'd0, vecs[row_idx].elast});
            chk($sformatf("tbl%0d.in_ready", row_idx), {31'd0, a_in_ready}, {31'd0, vecs[row_idx].eir});
            if (vecs[row_idx].evalid)
                chk($sformatf("tbl%0d.out_data", row_idx), {28'd0, a_data}, {28'd0, vecs[row_idx].edata});
        end
`ifdef VECTOR_UNPACKER_STATS_EN
        chk("a.word_cnt", {16'd0, a_cnt}, {16'd0, cnt_model});
`endif
        @(posedge clk);
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            qc.delete();
`ifdef VECTOR_UNPACKER_STATS_EN
            cnt_model = 16'h0000;
`endif
        end else begin
            if (sa > 0 && out_ready) begin
`ifdef VECTOR_UNPACKER_STATS_EN
                if (sa == 1) cnt_model = cnt_model + 16'h0001;
`endif
                void'(qa.pop_front());
            end
            if (sb > 0 && out_ready) void'(qb.pop_front());
            if (sc > 0 && out_ready) void'(qc.pop_front());
            if (in_valid && ir_a) begin
                qa.push_back(int'(in_data8[7:4]));
                qa.push_back(int'(in_data8[3:0]));
            end
            if (in_valid && ir_b) begin
                qb.push_back(int'(in_data8[3:0]));
                qb.push_back(int'(in_data8[7:4]));
            end
            if (in_valid && ir_c) begin
                qc.push_back(int'(in_data12[11:8]));
                qc.push_back(int'(in_data12[7:4]));
                qc.push_back(int'(in_data12[3:0]));
            end
        end
        #1;
    endtask

    initial begin
        //            din    vin   rdy   edata evalid elast eir
        vecs[0]  = '{8'hF5, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{8'h00, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{8'hA3, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h0E, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h0E, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{8'h5C, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'hFF, 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'h00, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};

        #12;
        chk("rst.out_valid", {31'd0, a_valid}, 32'd0);
        chk("rst.out_data", {28'd0, a_data}, 32'd0);
        chk("rst.out_last", {31'd0, a_last}, 32'd0);
        chk("rst.in_ready", {31'd0, a_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_data12 = 12'hABC;

        for (int i = 0; i < 15; i++) begin
            in_data8  = vecs[i].din;
            in_valid  = vecs[i].vin;
            out_ready = vecs[i].rdy;
            row_idx    = i;
            row_active = 1;
            step();
        end
        row_active = 0;

        // Reset in the middle of a word: the pending low slice must never appear.
        in_data8 = 8'hA3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {31'd0, a_valid}, 32'd0);
        chk("midrst.in_ready", {31'd0, a_in_ready}, 32'd0);
        qa.delete();
        qb.delete();
        qc.delete();
`ifdef VECTOR_UNPACKER_STATS_EN
        cnt_model = 16'h0000;
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data8  = 8'($urandom);
            in_data12 = 12'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
